// File: rtl/spi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_arbiter
// Purpose  : Round-robin sharing of one word-level SPI master among NUM_REQ
//            requesters, one active-low chip select per requester.
// Option   : SPI_ARB_TIMEOUT_EN enables the WAIT-state watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 16,
  parameter int GAP_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic                      o_rsp_err,
  output logic [NUM_REQ-1:0]        o_cs_n,
  output logic                      o_spi_start,
  output logic [DATA_W-1:0]         o_spi_tx_data,
  input  logic                      i_spi_done,
  input  logic [DATA_W-1:0]         i_spi_rx_data,
  output logic                      o_busy
);

  localparam int                 IDX_W      = $clog2(NUM_REQ);
  localparam int                 POS_W      = IDX_W + 1;
  localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [POS_W-1:0]   c_NUM_POS  = POS_W'(NUM_REQ);
  localparam logic [7:0]         c_GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] c_ONE      = NUM_REQ'(1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 1 || GAP_CYCLES > 255 ||
      TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("spi_master_arbiter: parameter out of legal range");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_RESP = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_idx;
  logic [7:0]          r_gap;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [NUM_REQ-1:0]  r_cs_n;
  logic                r_spi_start;
  logic [DATA_W-1:0]   r_spi_tx_data;
  logic                r_busy;

  logic                w_found;
  logic [IDX_W-1:0]    w_win;
  logic [POS_W-1:0]    w_pos;
  logic [DATA_W-1:0]   w_tx_word;

  // First set request at or above r_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = {1'b0, r_ptr} + POS_W'(k);
      if (w_pos >= c_NUM_POS) begin
        w_pos = w_pos - c_NUM_POS;
      end
      if (!w_found && i_req[w_pos[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_pos[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_tx_word = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win == IDX_W'(k)) begin
        w_tx_word = i_req_data[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int             TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0]           r_wdog;
  logic                      r_rsp_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_idx         <= '0;
      r_gap         <= '0;
      r_gnt         <= '0;
      r_rsp_valid   <= '0;
      r_rsp_data    <= '0;
      r_cs_n        <= '1;
      r_spi_start   <= 1'b0;
      r_spi_tx_data <= '0;
      r_busy        <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_wdog        <= '0;
      r_rsp_err     <= 1'b0;
`endif
    end else begin
      r_gnt       <= '0;
      r_spi_start <= 1'b0;
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_idx         <= w_win;
            r_gnt         <= c_ONE << w_win;
            r_cs_n        <= ~(c_ONE << w_win);
            r_spi_start   <= 1'b1;
            r_spi_tx_data <= w_tx_word;
            r_busy        <= 1'b1;
            r_state       <= S_LOAD;
          end
        end
        // A done pulse coincident with the start pulse is ignored here.
        S_LOAD: begin
`ifdef SPI_ARB_TIMEOUT_EN
          r_wdog  <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_spi_done) begin
            r_rsp_data  <= i_spi_rx_data;
            r_rsp_valid <= c_ONE << r_idx;
            r_state     <= S_RESP;
`ifdef SPI_ARB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (r_wdog == c_TO_LAST) begin
            r_rsp_data  <= '0;
            r_rsp_valid <= c_ONE << r_idx;
            r_rsp_err   <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_wdog      <= r_wdog + 1'b1;
`endif
          end
        end
        S_RESP: begin
          r_cs_n  <= '1;
          r_ptr   <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
          r_gap   <= '0;
          r_state <= S_GAP;
`ifdef SPI_ARB_TIMEOUT_EN
          r_rsp_err <= 1'b0;
`endif
        end
        S_GAP: begin
          if (r_gap == c_GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + 8'd1;
          end
        end
        default: begin
          r_cs_n  <= '1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  assign o_rsp_err = r_rsp_err;
`else
  assign o_rsp_err = 1'b0;
`endif

  assign o_gnt         = r_gnt;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_data    = r_rsp_data;
  assign o_cs_n        = r_cs_n;
  assign o_spi_start   = r_spi_start;
  assign o_spi_tx_data = r_spi_tx_data;
  assign o_busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_arbiter
// Purpose  : Directed, table-driven self-checking bench for spi_master_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int DATA_W         = 16;
  localparam int GAP_CYCLES     = 3;
  localparam int TIMEOUT_CYCLES = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  gnt, rsp_valid, cs_n;
  logic [15:0] rsp_data, spi_tx_data;
  logic        rsp_err, spi_start, busy;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rx_data = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(req), .i_req_data(req_data),
    .o_gnt(gnt), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
    .o_rsp_err(rsp_err), .o_cs_n(cs_n), .o_spi_start(spi_start),
    .o_spi_tx_data(spi_tx_data), .i_spi_done(spi_done),
    .i_spi_rx_data(spi_rx_data), .o_busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [63:0] data;
    logic [15:0] rx;
    int          wait_n;
    bit          load_done;
    bit          gap_done;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_cs;
    logic [15:0] exp_tx;
  } vec_t;

  vec_t       vecs [8];
  logic [3:0] rr_exp [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int last;
    int n;

    // Pointer evolution: 0 ->2 ->3 ->0 ->2 ->1 ->2 ->0 ->0
    vecs[0] = '{4'b0010, 64'h0000_0000_A5C3_0000, 16'h3C5A, 0, 1'b0, 1'b0, 4'b0010, 4'b1101, 16'hA5C3};
    vecs[1] = '{4'b1111, 64'h1111_2222_3333_4444, 16'h0F0F, 2, 1'b1, 1'b0, 4'b0100, 4'b1011, 16'h2222};
    vecs[2] = '{4'b1111, 64'h5A5A_6B6B_7C7C_8D8D, 16'hFFFF, 0, 1'b0, 1'b1, 4'b1000, 4'b0111, 16'h5A5A};
    vecs[3] = '{4'b1010, 64'hBEEF_0000_CAFE_0000, 16'h8001, 1, 1'b0, 1'b0, 4'b0010, 4'b1101, 16'hCAFE};
    vecs[4] = '{4'b0001, 64'h0000_0000_0000_F00D, 16'h7E7E, 3, 1'b1, 1'b1, 4'b0001, 4'b1110, 16'hF00D};
    vecs[5] = '{4'b0011, 64'h0000_0000_1234_5678, 16'hC3C3, 0, 1'b0, 1'b0, 4'b0010, 4'b1101, 16'h1234};
    vecs[6] = '{4'b1001, 64'h9ABC_0000_0000_DEF0, 16'h0101, 1, 1'b0, 1'b0, 4'b1000, 4'b0111, 16'h9ABC};
    vecs[7] = '{4'b1000, 64'h0001_0000_0000_0000, 16'hFEDC, 0, 1'b1, 1'b0, 4'b1000, 4'b0111, 16'h0001};
    rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_cs_n", cs_n, 4'b1111);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_spi_start", spi_start, 1'b0);
    chk("rst_tx_data", spi_tx_data, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      req      = vecs[v].req;
      req_data = vecs[v].data;
      tick();
      chk($sformatf("v%0d_gnt", v), gnt, vecs[v].exp_gnt);
      chk($sformatf("v%0d_start", v), spi_start, 1'b1);
      chk($sformatf("v%0d_tx", v), spi_tx_data, vecs[v].exp_tx);
      chk($sformatf("v%0d_cs_load", v), cs_n, vecs[v].exp_cs);
      chk($sformatf("v%0d_busy_load", v), busy, 1'b1);
      req         = '0;
      spi_done    = vecs[v].load_done;
      spi_rx_data = 16'hDEAD;
      tick();
      spi_done = 1'b0;
      chk($sformatf("v%0d_gnt_pulse", v), gnt, 4'b0000);
      chk($sformatf("v%0d_start_pulse", v), spi_start, 1'b0);
      chk($sformatf("v%0d_no_early_rsp", v), rsp_valid, 4'b0000);
      repeat (vecs[v].wait_n) tick();
      chk($sformatf("v%0d_cs_wait", v), cs_n, vecs[v].exp_cs);
      spi_rx_data = vecs[v].rx;
      spi_done    = 1'b1;
      tick();
      spi_done    = 1'b0;
      spi_rx_data = ~vecs[v].rx;
      chk($sformatf("v%0d_rsp_valid", v), rsp_valid, vecs[v].exp_gnt);
      chk($sformatf("v%0d_rsp_data", v), rsp_data, vecs[v].rx);
      chk($sformatf("v%0d_rsp_err", v), rsp_err, 1'b0);
      chk($sformatf("v%0d_cs_resp", v), cs_n, vecs[v].exp_cs);
      chk($sformatf("v%0d_tx_hold", v), spi_tx_data, vecs[v].exp_tx);
      tick();
      chk($sformatf("v%0d_cs_gap", v), cs_n, 4'b1111);
      chk($sformatf("v%0d_rsp_pulse", v), rsp_valid, 4'b0000);
      chk($sformatf("v%0d_rsp_hold", v), rsp_data, vecs[v].rx);
      spi_done = vecs[v].gap_done;
      tick();
      spi_done = 1'b0;
      tick();
      chk($sformatf("v%0d_busy_gap3", v), busy, 1'b1);
      chk($sformatf("v%0d_no_gap_rsp", v), rsp_valid, 4'b0000);
      tick();
      chk($sformatf("v%0d_busy_idle", v), busy, 1'b0);
    end

    // All requesters held: strict rotation, 7 cycles between grants.
    req      = 4'b1111;
    req_data = 64'h4444_3333_2222_1111;
    last     = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (gnt == 4'b0000 && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("rr%0d_gnt", k), gnt, rr_exp[k]);
      if (k > 0) chk($sformatf("rr%0d_spacing", k), cyc - last, 7);
      last = cyc;
      if (k == 4) req = '0;
      tick();
      spi_rx_data = 16'h0100 + 16'(k);
      spi_done    = 1'b1;
      tick();
      spi_done = 1'b0;
      chk($sformatf("rr%0d_rsp", k), rsp_valid, rr_exp[k]);
      chk($sformatf("rr%0d_data", k), rsp_data, 16'h0100 + 16'(k));
    end
    repeat (4) tick();
    chk("rr_idle", busy, 1'b0);

    // Reset while waiting on the master (ptr is 1 here).
    req      = 4'b1000;
    req_data = 64'h7777_0000_0000_0000;
    tick();
    chk("abort_gnt", gnt, 4'b1000);
    req = '0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", cs_n, 4'b1111);
    chk("abort_busy", busy, 1'b0);
    chk("abort_gnt0", gnt, 4'b0000);
    chk("abort_rsp", rsp_valid, 4'b0000);
    spi_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    spi_done = 1'b0;
    tick();
    chk("abort_no_rsp", rsp_valid, 4'b0000);
    chk("abort_idle", busy, 1'b0);
    req      = 4'b0101;
    req_data = 64'h0000_2468_0000_1357;
    tick();
    chk("post_rst_ptr", gnt, 4'b0001);
    chk("post_rst_tx", spi_tx_data, 16'h1357);
    req = '0;
    tick();
    spi_rx_data = 16'h55AA;
    spi_done    = 1'b1;
    tick();
    spi_done = 1'b0;
    chk("post_rst_rsp", rsp_valid, 4'b0001);
    repeat (4) tick();
    chk("post_rst_idle", busy, 1'b0);

    // Spurious done while idle.
    spi_done = 1'b1;
    tick();
    tick();
    spi_done = 1'b0;
    chk("idle_done_rsp", rsp_valid, 4'b0000);
    chk("idle_done_busy", busy, 1'b0);
    chk("idle_done_cs", cs_n, 4'b1111);
    tick();
    chk("idle_done_rsp2", rsp_valid, 4'b0000);
    chk("idle_done_data", rsp_data, 16'h55AA);

    // No done from the master (ptr is 1, so requester 0 wins by wrap).
    req      = 4'b0001;
    req_data = 64'h0000_0000_0000_ABCD;
    tick();
    chk("to_gnt", gnt, 4'b0001);
    req = '0;
    tick();
`ifdef SPI_ARB_TIMEOUT_EN
    repeat (7) tick();
    chk("to_not_yet", rsp_valid, 4'b0000);
    chk("to_cs_wait", cs_n, 4'b1110);
    tick();
    chk("to_rsp", rsp_valid, 4'b0001);
    chk("to_err", rsp_err, 1'b1);
    chk("to_data", rsp_data, 16'h0000);
    tick();
    chk("to_cs_rel", cs_n, 4'b1111);
    chk("to_err_clr", rsp_err, 1'b0);
    repeat (3) tick();
    chk("to_idle", busy, 1'b0);
`else
    repeat (20) tick();
    chk("nto_busy", busy, 1'b1);
    chk("nto_cs", cs_n, 4'b1110);
    chk("nto_rsp", rsp_valid, 4'b0000);
    spi_rx_data = 16'h0BAD;
    spi_done    = 1'b1;
    tick();
    spi_done = 1'b0;
    chk("nto_late_rsp", rsp_valid, 4'b0001);
    chk("nto_err", rsp_err, 1'b0);
    chk("nto_data", rsp_data, 16'h0BAD);
    repeat (4) tick();
    chk("nto_idle", busy, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one SPI master core (word-level start/done interface) among NUM_REQ requesters.
- Uses round-robin arbitration. Drives a dedicated active-low chip select per requester and sequences each transaction as: grant, start, wait for done, respond, inter-frame gap.
- Sits between the SPI master and client blocks such as ADC/DAC pollers.

Parameters:
- NUM_REQ, 4: number of requesters and chip-select lines; legal range 2..8.
- DATA_W, 16: SPI word width in bits; matches the master's data length.
- GAP_CYCLES, 3: clk cycles with all chip selects high between frames; legal range 1..255.
- TIMEOUT_CYCLES, 1024: WAIT-state watchdog limit; used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester transaction request, level; held until gnt.
- req_data  in  NUM_REQ*DATA_W  TX word; requester i uses slice [i*DATA_W +: DATA_W]; stable while req[i]=1.
- gnt  out  NUM_REQ  one-hot, one-cycle pulse; TX word accepted.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse; rsp_data valid for that requester.
- rsp_data  out  DATA_W  received word; holds its value until the next response.
- rsp_err  out  1  high with rsp_valid when the transaction timed out.
- cs_n  out  NUM_REQ  active-low chip selects; at most one low at any time.
- spi_start  out  1  one-cycle start pulse to the SPI master.
- spi_tx_data  out  DATA_W  word to shift out; stable from spi_start until spi_done.
- spi_done  in  1  one-cycle pulse from the master; spi_rx_data valid in the same cycle.
- spi_rx_data  in  DATA_W  word shifted in.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release) drives:
  - state=IDLE, ptr=0.
  - gnt=0, rsp_valid=0, rsp_err=0, rsp_data=0.
  - cs_n=all 1s, spi_start=0, spi_tx_data=0, busy=0.
- Reset asserted mid-transaction aborts it immediately: cs_n goes high asynchronously and no response is issued.
- States: IDLE, LOAD, WAIT, RESP, GAP.
- IDLE:
  - If req≠0, select winner i = first set bit scanning from ptr upward, wrapping modulo NUM_REQ.
  - Latch i, go to LOAD.
  - Winner is decided from the req value sampled in this cycle.
- LOAD (exactly 1 cycle):
  - gnt[i]=1.
  - spi_tx_data <= req_data slice i.
  - cs_n[i]=0, held low until RESP exits.
  - spi_start=1.
  - Go to WAIT.
  - Latency from req sampled in IDLE to gnt/spi_start: 1 cycle.
- WAIT:
  - Hold cs_n and spi_tx_data.
  - On spi_done: rsp_data <= spi_rx_data, go to RESP.
- RESP (1 cycle):
  - rsp_valid[i]=1, rsp_err=0.
  - cs_n returns to all 1s on exit.
  - ptr <= (i+1) mod NUM_REQ.
  - Go to GAP.
- GAP:
  - Count GAP_CYCLES cycles with cs_n all high, then go to IDLE.
  - Requests arriving in GAP wait; they are arbitrated in the first IDLE cycle.
- Boundary conditions:
  - spi_done outside WAIT is ignored.
  - spi_done in the same cycle as LOAD is ignored.
  - req[i] dropped before gnt: that requester is not served and nothing is recorded.
  - A requester re-asserting req in the cycle after its own rsp_valid is served only after all other pending requesters with higher round-robin priority.
  - All requesters asserted continuously: service order i, i+1, ... with wrap. No starvation; worst-case wait is NUM_REQ-1 transactions.
- The ptr counter wraps from NUM_REQ-1 to 0.
- gnt, rsp_valid, and cs_n low-bits always select the same index within one transaction.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without spi_done, go to RESP with rsp_err=1 and rsp_data=0, then GAP as normal.
  - A spi_done arriving in the timeout cycle takes priority: normal response with rsp_err=0.
- Undefined:
  - No counter; WAIT lasts until spi_done, indefinitely if necessary.
  - rsp_err is tied 0.

Test Plan (NUM_REQ=4, DATA_W=16, GAP_CYCLES=3):
1. Reset check: assert rst_n=0 mid-WAIT -> cs_n=4'b1111, busy=0, gnt/rsp_valid=0 the same cycle. After release, a single req[2] is granted first (ptr=0 scan reaches 2).
2. Single transaction: req=4'b0010, req_data[31:16]=16'hA5C3 -> next cycle gnt=4'b0010, spi_start=1, spi_tx_data=16'hA5C3, cs_n=4'b1101. Master returns spi_done with 16'h3C5A -> next cycle rsp_valid=4'b0010, rsp_data=16'h3C5A. Then 3 cycles with cs_n=4'b1111 before busy=0.
3. Round-robin fairness: req=4'b1111 held continuously -> grant order 0,1,2,3,0. Each gnt is separated by transaction time plus 3 GAP cycles.
4. Wrap-around: after serving 3 (ptr=0), req=4'b1010 -> requester 1 is granted before 3.
5. Spurious done: pulse spi_done in IDLE and GAP -> no rsp_valid; state unchanged.
6. Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): req[0], no spi_done -> after 8 WAIT cycles, rsp_valid=4'b0001, rsp_err=1, rsp_data=0, cs_n released. Without the macro, busy stays 1 and cs_n[0] stays 0.
